// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Memory responder for the pipelined LC-3b core. Two initiators share one
// physical memory port, and only one transaction is in flight at a time:
//   - I port: instruction fetch, read-only.
//   - D port: data access, read or write.
// The D port wins arbitration so that the older in-flight instruction is never
// blocked behind a younger fetch. A starvation counter bounds how many D grants
// in a row may pass a pending fetch before the fetch is forced through.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   i_read, i_address       instruction request (held until i_resp)
//   i_rdata, i_resp         instruction data and one-cycle completion pulse
//   d_read, d_write         data request (held until d_resp)
//   d_byte_enable           data write byte lanes
//   d_address, d_wdata      data address and write data
//   d_rdata, d_resp         data read data and one-cycle completion pulse
//   pmem_read, pmem_write   physical strobes, stable for the whole access
//   pmem_byte_enable        physical byte lanes
//   pmem_address            physical address
//   pmem_wdata              physical write data
//   pmem_rdata, pmem_resp   physical read data and completion
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [1:0]        d_byte_enable,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [1:0]        pmem_byte_enable,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_r;
  logic [3:0] starve_cnt_r;

  logic d_req_s;
  logic i_forced_s;
  logic grant_d_s;
  logic grant_i_s;

  // Arbitration decision for the IDLE state: D first unless a fetch has been
  // passed over LIMIT times in a row.
  always_comb begin
    d_req_s    = d_read | d_write;
    i_forced_s = i_read && (starve_cnt_r == LIMIT);
    grant_d_s  = 1'b0;
    grant_i_s  = 1'b0;
    if (d_req_s && !i_forced_s) begin
      grant_d_s = 1'b1;
    end else if (i_read) begin
      grant_i_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
      grant_i_s = 1'b0;
    end
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      starve_cnt_r     <= 4'd0;
      i_rdata          <= '0;
      i_resp           <= 1'b0;
      d_rdata          <= '0;
      d_resp           <= 1'b0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_byte_enable <= 2'b00;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
    end else begin
      // Completion pulses are high only in the cycle spent in DONE_x.
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_d_s) begin
            state_r          <= SERVE_D;
            pmem_address     <= d_address;
            pmem_wdata       <= d_wdata;
            pmem_byte_enable <= d_byte_enable;
            // Write takes precedence when both read and write are requested.
            pmem_write       <= d_write;
            pmem_read        <= ~d_write;
            if (!i_read) begin
              starve_cnt_r <= 4'd0;
            end else if (starve_cnt_r != LIMIT) begin
              starve_cnt_r <= starve_cnt_r + 4'd1;
            end else begin
              starve_cnt_r <= starve_cnt_r;
            end
          end else if (grant_i_s) begin
            state_r          <= SERVE_I;
            pmem_address     <= i_address;
            pmem_wdata       <= '0;
            pmem_byte_enable <= 2'b11;
            pmem_write       <= 1'b0;
            pmem_read        <= 1'b1;
            starve_cnt_r     <= 4'd0;
          end else begin
            state_r <= IDLE;
          end
        end
        SERVE_I: begin
          if (pmem_resp) begin
            i_rdata    <= pmem_rdata;
            i_resp     <= 1'b1;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            state_r    <= DONE_I;
          end else begin
            state_r <= SERVE_I;
          end
        end
        SERVE_D: begin
          if (pmem_resp) begin
            d_rdata    <= pmem_rdata;
            d_resp     <= 1'b1;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            state_r    <= DONE_D;
          end else begin
            state_r <= SERVE_D;
          end
        end
        DONE_I: begin
          state_r <= IDLE;
        end
        DONE_D: begin
          state_r <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 time unit after
// the rising edge and outputs are checked at the same point, so each tick()
// advances exactly one cycle of the numbered latency sequence.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_read;
  logic [15:0] i_address;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [1:0]  d_byte_enable;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_byte_enable(pmem_byte_enable), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " i_resp"}, {31'd0, i_resp}, 32'd0);
    check({tag, " d_resp"}, {31'd0, d_resp}, 32'd0);
    check({tag, " i_rdata"}, {16'd0, i_rdata}, 32'd0);
    check({tag, " d_rdata"}, {16'd0, d_rdata}, 32'd0);
    check({tag, " pmem_read"}, {31'd0, pmem_read}, 32'd0);
    check({tag, " pmem_write"}, {31'd0, pmem_write}, 32'd0);
    check({tag, " pmem_be"}, {30'd0, pmem_byte_enable}, 32'd0);
    check({tag, " pmem_address"}, {16'd0, pmem_address}, 32'd0);
    check({tag, " pmem_wdata"}, {16'd0, pmem_wdata}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; i_read = 1'b0; i_address = 16'h0000;
    d_read = 1'b0; d_write = 1'b0; d_byte_enable = 2'b00;
    d_address = 16'h0000; d_wdata = 16'h0000;
    pmem_rdata = 16'h0000; pmem_resp = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: single I read, zero-wait memory
    i_read = 1'b1; i_address = 16'h0040;                       // cycle 0
    tick();                                                    // cycle 1
    check("t1 pmem_read", {31'd0, pmem_read}, 32'd1);
    check("t1 pmem_write", {31'd0, pmem_write}, 32'd0);
    check("t1 pmem_address", {16'd0, pmem_address}, 32'h0040);
    check("t1 pmem_be", {30'd0, pmem_byte_enable}, 32'd3);
    check("t1 i_resp early", {31'd0, i_resp}, 32'd0);
    pmem_resp = 1'b1; pmem_rdata = 16'h1234;
    tick();                                                    // cycle 2
    check("t1 i_resp", {31'd0, i_resp}, 32'd1);
    check("t1 i_rdata", {16'd0, i_rdata}, 32'h1234);
    check("t1 d_resp", {31'd0, d_resp}, 32'd0);
    check("t1 strobe off", {31'd0, pmem_read}, 32'd0);
    i_read = 1'b0; pmem_resp = 1'b0;
    tick();                                                    // cycle 3
    check("t1 i_resp pulse", {31'd0, i_resp}, 32'd0);
    check("t1 i_rdata hold", {16'd0, i_rdata}, 32'h1234);

    // 2: D write, memory responds in the third strobe cycle
    d_write = 1'b1; d_address = 16'h00A2; d_wdata = 16'hBEEF; d_byte_enable = 2'b10;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("t2 pmem_write", {31'd0, pmem_write}, 32'd1);
      check("t2 pmem_read", {31'd0, pmem_read}, 32'd0);
      check("t2 pmem_address", {16'd0, pmem_address}, 32'h00A2);
      check("t2 pmem_wdata", {16'd0, pmem_wdata}, 32'hBEEF);
      check("t2 pmem_be", {30'd0, pmem_byte_enable}, 32'd2);
      check("t2 d_resp early", {31'd0, d_resp}, 32'd0);
      if (c == 3) begin
        pmem_resp = 1'b1; pmem_rdata = 16'h0F0F;
      end else begin
        pmem_resp = 1'b0;
      end
    end
    tick();
    check("t2 d_resp", {31'd0, d_resp}, 32'd1);
    check("t2 pmem_write off", {31'd0, pmem_write}, 32'd0);
    check("t2 pmem_read", {31'd0, pmem_read}, 32'd0);
    d_write = 1'b0; pmem_resp = 1'b0;
    tick();
    check("t2 d_resp pulse", {31'd0, d_resp}, 32'd0);

    // 3: simultaneous I and D read; D first, I right after D's DONE cycle
    i_read = 1'b1; i_address = 16'h0200;
    d_read = 1'b1; d_address = 16'h0100;
    tick();                                                    // cycle 1
    check("t3 D first addr", {16'd0, pmem_address}, 32'h0100);
    check("t3 strobes", {30'd0, pmem_read, pmem_write}, 32'd2);
    pmem_resp = 1'b1; pmem_rdata = 16'h5555;
    tick();                                                    // cycle 2 DONE_D
    check("t3 d_resp", {31'd0, d_resp}, 32'd1);
    check("t3 d_rdata", {16'd0, d_rdata}, 32'h5555);
    check("t3 i_resp", {31'd0, i_resp}, 32'd0);
    d_read = 1'b0; pmem_resp = 1'b0;
    tick();                                                    // cycle 3 IDLE
    check("t3 idle strobe", {31'd0, pmem_read}, 32'd0);
    tick();                                                    // cycle 4
    check("t3 I addr", {16'd0, pmem_address}, 32'h0200);
    check("t3 I strobes", {30'd0, pmem_read, pmem_write}, 32'd2);
    pmem_resp = 1'b1; pmem_rdata = 16'h6666;
    tick();                                                    // cycle 5
    check("t3 i_resp", {31'd0, i_resp}, 32'd1);
    check("t3 i_rdata", {16'd0, i_rdata}, 32'h6666);
    check("t3 d_rdata hold", {16'd0, d_rdata}, 32'h5555);
    i_read = 1'b0; pmem_resp = 1'b0;
    tick();

    // 4: starvation; 4 D grants, 5th to I, then D again (counter cleared)
    i_read = 1'b1; i_address = 16'h0300;
    d_read = 1'b1; d_address = 16'h0400;
    for (int g = 0; g < 6; g++) begin
      tick();                                                  // SERVE
      check("t4 grant addr", {16'd0, pmem_address}, (g == 4) ? 32'h0300 : 32'h0400);
      check("t4 strobes", {30'd0, pmem_read, pmem_write}, 32'd2);
      pmem_resp = 1'b1; pmem_rdata = 16'(16'hA000 + g);
      tick();                                                  // DONE
      check("t4 i_resp", {31'd0, i_resp}, (g == 4) ? 32'd1 : 32'd0);
      check("t4 d_resp", {31'd0, d_resp}, (g == 4) ? 32'd0 : 32'd1);
      pmem_resp = 1'b0;
      if (g == 5) begin
        i_read = 1'b0; d_read = 1'b0;
      end
      tick();                                                  // IDLE
    end
    check("t4 i_rdata", {16'd0, i_rdata}, 32'hA004);
    check("t4 d_rdata", {16'd0, d_rdata}, 32'hA005);

    // 5: read and write both high; write wins
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h0010;
    d_wdata = 16'h00FF; d_byte_enable = 2'b11;
    tick();
    check("t5 pmem_write", {31'd0, pmem_write}, 32'd1);
    check("t5 pmem_read", {31'd0, pmem_read}, 32'd0);
    pmem_resp = 1'b1; pmem_rdata = 16'h0000;
    tick();
    check("t5 d_resp", {31'd0, d_resp}, 32'd1);
    d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    tick();

    // 6: reset during SERVE_D, stray pmem_resp afterwards
    d_read = 1'b1; d_address = 16'h0500; d_byte_enable = 2'b01; d_wdata = 16'h1111;
    tick();                                                    // SERVE_D
    check("t6 pmem_read", {31'd0, pmem_read}, 32'd1);
    rst_n = 1'b0; d_read = 1'b0;
    tick();
    check_idle_outputs("t6 reset");
    rst_n = 1'b1;
    tick();
    pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
    tick();
    check_idle_outputs("t6 stray");
    pmem_resp = 1'b0;
    i_read = 1'b1; i_address = 16'h0600;
    tick();
    check("t6 I pmem_read", {31'd0, pmem_read}, 32'd1);
    check("t6 I addr", {16'd0, pmem_address}, 32'h0600);
    pmem_resp = 1'b1; pmem_rdata = 16'h7777;
    tick();
    check("t6 i_resp", {31'd0, i_resp}, 32'd1);
    check("t6 i_rdata", {16'd0, i_rdata}, 32'h7777);
    check("t6 d_resp", {31'd0, d_resp}, 32'd0);
    i_read = 1'b0; pmem_resp = 1'b0;
    tick();
    check("t6 i_resp pulse", {31'd0, i_resp}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
